// File: rtl/sigcapture_if.sv
// Sample-capture bus: stream input, trigger setup, readback port and status.
// The master side drives the stream and readback address; the slave is the capture buffer.
interface sigcapture_if #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  en;
   logic [WIDTH-1:0]      din;
   logic                  arm;
   logic [WIDTH-1:0]      thresh;
   logic [ADDR_WIDTH-1:0] pre;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [WIDTH-1:0]      rd_data;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [ADDR_WIDTH-1:0] trig_addr;

   modport master (
      output en, din, arm, thresh, pre, rd_addr,
      input  rd_data, busy, done, start_addr, trig_addr
   );

   modport slave (
      input  en, din, arm, thresh, pre, rd_addr,
      output rd_data, busy, done, start_addr, trig_addr
   );
endinterface

// File: rtl/sigcapture.sv
// Triggered capture buffer: writes a sample stream into a circular RAM and freezes
// a DEPTH-sample window around a rising threshold crossing; registered readback.
module sigcapture #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   sigcapture_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_POST, S_DONE} state_t;

   state_t                state, state_nx;
   logic [WIDTH-1:0]      ram [DEPTH];
   logic [ADDR_WIDTH-1:0] wptr, fill_cnt, pre_q, post_cnt;
   logic [ADDR_WIDTH-1:0] trig_addr_q, start_addr_q;
   logic [ADDR_WIDTH-1:0] fill_inc, post_init;
   logic [WIDTH-1:0]      prev, rd_data_q;
   logic                  prev_valid, busy_q, done_q;
   logic                  wr, trig, arm_ok;

   // NOTE: every signal written here gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_nx  = state;
      wr        = 1'b0;
      trig      = 1'b0;
      arm_ok    = 1'b0;
      fill_inc  = fill_cnt + ONE;
      post_init = {ADDR_WIDTH{1'b1}} - pre_q;
      case (state)
         S_IDLE, S_DONE: begin
            if (bus.arm) begin
               arm_ok   = 1'b1;
               state_nx = (bus.pre == '0) ? S_WAIT : S_FILL;
            end
         end
         S_FILL: begin
            if (bus.en) begin
               wr = 1'b1;
               if (fill_inc == pre_q) state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.en) begin
               wr = 1'b1;
               if (prev_valid && (prev < bus.thresh) && (bus.din >= bus.thresh)) begin
                  trig     = 1'b1;
                  state_nx = (post_init == '0) ? S_DONE : S_POST;
               end
            end
         end
         S_POST: begin
            if (bus.en) begin
               wr = 1'b1;
               if (post_cnt == ONE) state_nx = S_DONE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         wptr         <= '0;
         fill_cnt     <= '0;
         pre_q        <= '0;
         post_cnt     <= '0;
         trig_addr_q  <= '0;
         start_addr_q <= '0;
         prev         <= '0;
         prev_valid   <= 1'b0;
         rd_data_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state     <= state_nx;
         busy_q    <= (state_nx == S_FILL) || (state_nx == S_WAIT) || (state_nx == S_POST);
         done_q    <= (state_nx == S_DONE);
         rd_data_q <= ram[bus.rd_addr];
         if (arm_ok) begin
            pre_q      <= bus.pre;
            fill_cnt   <= '0;
            prev_valid <= 1'b0;
         end
         if (wr) begin
            wptr       <= wptr + ONE;
            prev       <= bus.din;
            prev_valid <= 1'b1;
         end
         if (wr && state == S_FILL) fill_cnt <= fill_inc;
         if (trig) begin
            trig_addr_q  <= wptr;
            start_addr_q <= wptr - pre_q;
            post_cnt     <= post_init;
         end else if (wr && state == S_POST) begin
            post_cnt <= post_cnt - ONE;
         end
      end
   end

   // NOTE: the sample RAM is deliberately left out of reset so it maps onto plain block memory.
   always_ff @(posedge clk) begin
      if (wr) ram[wptr] <= bus.din;
   end

   assign bus.rd_data    = rd_data_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.trig_addr  = trig_addr_q;
   assign bus.start_addr = start_addr_q;
endmodule

// File: tb/tb_sigcapture.sv
// Directed bench for sigcapture at DEPTH 16: ramp, boundary pre values, wrap-around,
// stalls with ignored re-arm, and asynchronous reset behaviour.
module tb_sigcapture;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   sigcapture_if #(.WIDTH(8), .ADDR_WIDTH(4)) bus ();

   sigcapture #(.WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp(input logic e, input logic [7:0] d);
      bus.en  = e;
      bus.din = d;
      tick();
      bus.en  = 1'b0;
   endtask

   task automatic arm_cap(input logic [3:0] p, input logic [7:0] t);
      bus.arm    = 1'b1;
      bus.pre    = p;
      bus.thresh = t;
      bus.en     = 1'b0;
      tick();
      bus.arm = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] d);
      bus.rd_addr = a;
      tick();
      d = bus.rd_data;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      rst         = 1'b0;
      bus.en      = 1'b0;
      bus.din     = '0;
      bus.arm     = 1'b0;
      bus.thresh  = '0;
      bus.pre     = '0;
      bus.rd_addr = '0;
      repeat (3) tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_status: busy=%0b done=%0b expected 0 0", bus.busy, bus.done);
      end
      n_checks++;
      if (bus.trig_addr !== 4'd0 || bus.start_addr !== 4'd0 || bus.rd_data !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_regs: trig=%0d start=%0d rd=%0h expected 0 0 0",
                  bus.trig_addr, bus.start_addr, bus.rd_data);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_ramp();
      logic [7:0] d;
      arm_cap(4'd4, 8'd10);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         n_errors++;
         $display("FAIL ramp_arm: busy=%0b done=%0b expected 1 0", bus.busy, bus.done);
      end
      for (int k = 0; k < 22; k++) begin
         smp(1'b1, 8'(k));
         if (k == 10) begin
            n_checks++;
            if (bus.trig_addr !== 4'd10 || bus.start_addr !== 4'd6) begin
               n_errors++;
               $display("FAIL ramp_trig: trig=%0d start=%0d expected 10 6",
                        bus.trig_addr, bus.start_addr);
            end
         end
         if (k == 20) begin
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
               n_errors++;
               $display("FAIL ramp_early_done: busy=%0b done=%0b expected 1 0", bus.busy, bus.done);
            end
         end
      end
      n_checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL ramp_done: busy=%0b done=%0b expected 0 1", bus.busy, bus.done);
      end
      for (int i = 0; i < 16; i++) begin
         rd(4'(6 + i), d);
         n_checks++;
         if (d !== 8'(6 + i)) begin
            n_errors++;
            $display("FAIL ramp_read[%0d]: got %0d expected %0d", i, d, 6 + i);
         end
      end
   endtask

   task automatic test_reset_midrun();
      logic [7:0] d;
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.trig_addr !== 4'd0 ||
          bus.start_addr !== 4'd0 || bus.rd_data !== 8'd0) begin
         n_errors++;
         $display("FAIL midrun_reset: busy=%0b done=%0b trig=%0d start=%0d rd=%0h expected all 0",
                  bus.busy, bus.done, bus.trig_addr, bus.start_addr, bus.rd_data);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < 16; k++) smp(1'b1, 8'hAA);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_errors++;
         $display("FAIL idle_no_arm: busy=%0b done=%0b expected 0 0", bus.busy, bus.done);
      end
      rd(4'd0, d);
      n_checks++;
      if (d !== 8'd16) begin
         n_errors++;
         $display("FAIL idle_no_write: ram[0]=%0h expected 10", d);
      end
   endtask

   task automatic test_boundary_pre();
      arm_cap(4'd0, 8'h80);
      smp(1'b1, 8'h90);
      smp(1'b1, 8'h10);
      smp(1'b1, 8'h80);
      n_checks++;
      if (bus.trig_addr !== 4'd2 || bus.start_addr !== 4'd2 || bus.busy !== 1'b1) begin
         n_errors++;
         $display("FAIL pre0_trig: trig=%0d start=%0d busy=%0b expected 2 2 1",
                  bus.trig_addr, bus.start_addr, bus.busy);
      end
      for (int k = 0; k < 14; k++) smp(1'b1, 8'(k));
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         n_errors++;
         $display("FAIL pre0_post14: busy=%0b done=%0b expected 1 0", bus.busy, bus.done);
      end
      smp(1'b1, 8'h0E);
      n_checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL pre0_post15: busy=%0b done=%0b expected 0 1", bus.busy, bus.done);
      end
      arm_cap(4'd15, 8'h80);
      for (int k = 0; k < 15; k++) smp(1'b1, 8'h01);
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         n_errors++;
         $display("FAIL pre15_fill: busy=%0b done=%0b expected 1 0", bus.busy, bus.done);
      end
      smp(1'b1, 8'h80);
      n_checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 ||
          bus.trig_addr !== 4'd1 || bus.start_addr !== 4'd2) begin
         n_errors++;
         $display("FAIL pre15_trig: busy=%0b done=%0b trig=%0d start=%0d expected 0 1 1 2",
                  bus.busy, bus.done, bus.trig_addr, bus.start_addr);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] d;
      logic [7:0] exp_win [16];
      pulse_reset();
      arm_cap(4'd0, 8'h80);
      for (int k = 0; k < 14; k++) smp(1'b1, 8'h00);
      smp(1'b1, 8'h80);
      for (int k = 0; k < 15; k++) smp(1'b1, 8'h00);
      n_checks++;
      if (bus.trig_addr !== 4'd14 || bus.done !== 1'b1) begin
         n_errors++;
         $display("FAIL wrap_prep: trig=%0d done=%0b expected 14 1", bus.trig_addr, bus.done);
      end
      arm_cap(4'd3, 8'h80);
      for (int k = 1; k <= 4; k++) smp(1'b1, 8'(8'h40 + k));
      smp(1'b1, 8'h85);
      n_checks++;
      if (bus.trig_addr !== 4'd2 || bus.start_addr !== 4'd15) begin
         n_errors++;
         $display("FAIL wrap_trig: trig=%0d start=%0d expected 2 15", bus.trig_addr, bus.start_addr);
      end
      for (int k = 1; k <= 12; k++) smp(1'b1, 8'(8'h90 + k));
      n_checks++;
      if (bus.done !== 1'b1) begin
         n_errors++;
         $display("FAIL wrap_done: done=%0b expected 1", bus.done);
      end
      exp_win[0] = 8'h42;
      exp_win[1] = 8'h43;
      exp_win[2] = 8'h44;
      exp_win[3] = 8'h85;
      for (int k = 1; k <= 12; k++) exp_win[3 + k] = 8'(8'h90 + k);
      for (int i = 0; i < 16; i++) begin
         rd(4'(15 + i), d);
         n_checks++;
         if (d !== exp_win[i]) begin
            n_errors++;
            $display("FAIL wrap_read[%0d]: got %0h expected %0h", i, d, exp_win[i]);
         end
      end
   endtask

   task automatic test_stall_rearm();
      logic [7:0] d;
      logic [7:0] exp_win [16];
      arm_cap(4'd2, 8'h50);
      smp(1'b1, 8'h10);
      smp(1'b0, 8'hFF);
      smp(1'b1, 8'h11);
      smp(1'b0, 8'hFF);
      smp(1'b1, 8'h12);
      arm_cap(4'd7, 8'h50);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         n_errors++;
         $display("FAIL stall_rearm_ignored: busy=%0b done=%0b expected 1 0", bus.busy, bus.done);
      end
      smp(1'b0, 8'hFF);
      smp(1'b1, 8'h60);
      n_checks++;
      if (bus.trig_addr !== 4'd2 || bus.start_addr !== 4'd0) begin
         n_errors++;
         $display("FAIL stall_trig: trig=%0d start=%0d expected 2 0", bus.trig_addr, bus.start_addr);
      end
      for (int j = 0; j < 13; j++) begin
         smp(1'b1, 8'(8'h20 + j));
         smp(1'b0, 8'hFF);
      end
      n_checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL stall_done: busy=%0b done=%0b expected 0 1", bus.busy, bus.done);
      end
      exp_win[0] = 8'h11;
      exp_win[1] = 8'h12;
      exp_win[2] = 8'h60;
      for (int j = 0; j < 13; j++) exp_win[3 + j] = 8'(8'h20 + j);
      for (int i = 0; i < 16; i++) begin
         rd(4'(i), d);
         n_checks++;
         if (d !== exp_win[i]) begin
            n_errors++;
            $display("FAIL stall_read[%0d]: got %0h expected %0h", i, d, exp_win[i]);
         end
      end
      arm_cap(4'd0, 8'h50);
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         n_errors++;
         $display("FAIL rearm_done: busy=%0b done=%0b expected 1 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_async_reset_post();
      smp(1'b1, 8'h00);
      smp(1'b1, 8'h90);
      smp(1'b1, 8'h01);
      smp(1'b1, 8'h02);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.trig_addr !== 4'd1) begin
         n_errors++;
         $display("FAIL areset_inpost: busy=%0b trig=%0d expected 1 1", bus.busy, bus.trig_addr);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.trig_addr !== 4'd0 || bus.start_addr !== 4'd0) begin
         n_errors++;
         $display("FAIL areset_async: busy=%0b done=%0b trig=%0d start=%0d expected 0 0 0 0",
                  bus.busy, bus.done, bus.trig_addr, bus.start_addr);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      smp(1'b1, 8'h00);
      smp(1'b1, 8'h90);
      for (int k = 0; k < 16; k++) smp(1'b1, 8'(k));
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_errors++;
         $display("FAIL areset_idle: busy=%0b done=%0b expected 0 0", bus.busy, bus.done);
      end
      arm_cap(4'd0, 8'h50);
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_errors++;
         $display("FAIL areset_rearm: busy=%0b expected 1", bus.busy);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_ramp();
      test_reset_midrun();
      test_boundary_pre();
      test_wrap();
      test_stall_rearm();
      test_async_reset_post();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
